// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock design: FSM state encoding, digit width,
// and small display-decoding helpers used by the LED / seven-segment drivers.
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCheck   = 3'd1,
    StOpen    = 3'd2,
    StChg     = 3'd3,
    StLockout = 3'd4
  } lock_state_e;

  // Active-high segments, bit 0 = a ... bit 6 = g. Letters: L, C, O, H, A, '-'.
  function automatic logic [6:0] state_to_seg(logic [2:0] st);
    logic [6:0] seg;
    case (st)
      3'd0:    seg = 7'b0111000;
      3'd1:    seg = 7'b0111001;
      3'd2:    seg = 7'b0111111;
      3'd3:    seg = 7'b1110110;
      3'd4:    seg = 7'b1110111;
      default: seg = 7'b1000000;
    endcase
    return seg;
  endfunction

  // Thermometer code for a three-LED attempts bar.
  function automatic logic [2:0] tries_to_leds(logic [2:0] n);
    return {n >= 3'd3, n >= 3'd2, n >= 3'd1};
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter that saturates at zero; done_o flags the zero count.
module lockout_timer #(
  parameter int unsigned  LOCK_CYCLES = 50_000_000,
  localparam int unsigned CntW        = $clog2(LOCK_CYCLES)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pwd_seq_ctrl.sv
// Password sequencer: collects DIGITS nibbles per entry, compares to the stored password,
// counts failed attempts, enforces a timed lockout and supports password change when open.
module pwd_seq_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned               DIGITS      = 4,
  parameter int unsigned               ATTEMPTS    = 3,
  parameter int unsigned               LOCK_CYCLES = 50_000_000,
  parameter logic [DIGIT_W*DIGITS-1:0] DEFAULT_PWD = 16'h1234
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_pulse,
  input  logic [3:0]   code,
  input  logic         mode,
  output logic         unlocked,
  output logic         alarm,
  output logic [2:0]   tries_left,
  output logic [2:0]   digit_cnt,
  output logic [2:0]   state
);

  localparam int unsigned PwdW     = DIGIT_W * DIGITS;
  localparam int unsigned CntW     = $clog2(LOCK_CYCLES);
  localparam logic [2:0]  LastDig  = 3'(DIGITS - 1);
  localparam logic [2:0]  AttMax   = 3'(ATTEMPTS);

  lock_state_e     state_q, state_d;
  logic [PwdW-1:0] pwd_q, pwd_d;
  logic [PwdW-1:0] buf_q, buf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      tries_q, tries_d;
  logic            unlocked_q, alarm_q;
  logic            timer_load, timer_done;
  logic [PwdW-1:0] buf_shift;

  // New digit enters at the LSB so the first-entered digit ends up most significant.
  assign buf_shift = PwdW'({buf_q, code});

  lockout_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (timer_load),
    .load_val_i (CntW'(LOCK_CYCLES - 1)),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    pwd_d      = pwd_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    timer_load = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_pulse) begin
          buf_d = buf_shift;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LastDig) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == pwd_q) begin
          state_d = StOpen;
          tries_d = AttMax;
        end else if (tries_q > 3'd1) begin
          state_d = StIdle;
          tries_d = tries_q - 3'd1;
        end else begin
          state_d    = StLockout;
          tries_d    = '0;
          timer_load = 1'b1;
        end
      end
      StOpen: begin
        if (key_pulse) begin
          state_d = mode ? StChg : StIdle;
        end
      end
      StChg: begin
        // Dropping mode aborts even if a digit is confirmed in the same cycle.
        if (!mode) begin
          state_d = StOpen;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (key_pulse) begin
          if (cnt_q == LastDig) begin
            state_d = StIdle;
            pwd_d   = buf_shift;
            buf_d   = '0;
            cnt_d   = '0;
            tries_d = AttMax;
          end else begin
            buf_d = buf_shift;
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StLockout: begin
        if (timer_done) begin
          state_d = StIdle;
          tries_d = AttMax;
        end
      end
      default: begin
        state_d = StIdle;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pwd_q      <= DEFAULT_PWD;
      buf_q      <= '0;
      cnt_q      <= '0;
      tries_q    <= AttMax;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwd_q      <= pwd_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      tries_q    <= tries_d;
      unlocked_q <= (state_d == StOpen);
      alarm_q    <= (state_d == StLockout);
    end
  end

  assign unlocked   = unlocked_q;
  assign alarm      = alarm_q;
  assign tries_left = tries_q;
  assign digit_cnt  = cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pwd_seq_ctrl.sv
// Self-checking bench for pwd_seq_ctrl: vector table, directed corner sequences and a
// randomized run against a queue-based behavioural model.
module tb_pwd_seq_ctrl;

  localparam int D  = 4;
  localparam int A  = 3;
  localparam int LC = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_pulse;
  logic [3:0] code;
  logic       mode;
  logic       unlocked;
  logic       alarm;
  logic [2:0] tries_left;
  logic [2:0] digit_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  pwd_seq_ctrl #(
    .DIGITS      (D),
    .ATTEMPTS    (A),
    .LOCK_CYCLES (LC),
    .DEFAULT_PWD (16'h1234)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_pulse  (key_pulse),
    .code       (code),
    .mode       (mode),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .tries_left (tries_left),
    .digit_cnt  (digit_cnt),
    .state      (state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: flags for where the user is, a queue of entered digits.
  bit          m_open, m_chg, m_chk;
  int          m_lock;
  int          m_q[$];
  logic [15:0] m_pwd;
  int          m_tries;

  function automatic void model_reset();
    m_open  = 0;
    m_chg   = 0;
    m_chk   = 0;
    m_lock  = 0;
    m_q.delete();
    m_pwd   = 16'h1234;
    m_tries = A;
  endfunction

  function automatic logic [15:0] model_word();
    logic [15:0] w = '0;
    foreach (m_q[i]) w = (w << 4) | 16'(m_q[i]);
    return w;
  endfunction

  function automatic int model_state();
    if (m_lock > 0) return 4;
    if (m_chk) return 1;
    if (m_chg) return 3;
    if (m_open) return 2;
    return 0;
  endfunction

  function automatic void model_step(bit k, logic [3:0] c, bit md);
    logic [15:0] w;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = A;
    end else if (m_chk) begin
      w = model_word();
      m_q.delete();
      m_chk = 0;
      if (w == m_pwd) begin
        m_open  = 1;
        m_tries = A;
      end else if (m_tries > 1) begin
        m_tries--;
      end else begin
        m_tries = 0;
        m_lock  = LC;
      end
    end else if (m_chg) begin
      if (!md) begin
        m_chg  = 0;
        m_open = 1;
        m_q.delete();
      end else if (k) begin
        m_q.push_back(int'(c));
        if (m_q.size() == D) begin
          m_pwd = model_word();
          m_q.delete();
          m_chg   = 0;
          m_tries = A;
        end
      end
    end else if (m_open) begin
      if (k) begin
        m_open = 0;
        m_chg  = md;
      end
    end else if (k) begin
      m_q.push_back(int'(c));
      if (m_q.size() == D) m_chk = 1;
    end
  endfunction

  task automatic check(string name, int st, bit unl, bit al, int tr, int dc);
    n_cmp++;
    if (state !== 3'(st) || unlocked !== unl || alarm !== al ||
        tries_left !== 3'(tr) || digit_cnt !== 3'(dc)) begin
      n_bad++;
      $display("FAIL %s @%0t: got st=%0d unl=%0b al=%0b tries=%0d cnt=%0d, want st=%0d unl=%0b al=%0b tries=%0d cnt=%0d",
               name, $time, state, unlocked, alarm, tries_left, digit_cnt, st, unl, al, tr, dc);
    end
  endtask

  task automatic check_model(string name);
    int s = model_state();
    check(name, s, s == 2, s == 4, m_tries, m_q.size());
  endtask

  // Called at a negedge; drives one cycle and checks just after the rising edge.
  task automatic step(bit k, logic [3:0] c, bit md, string name);
    key_pulse = k;
    code      = c;
    mode      = md;
    @(posedge clk);
    model_step(k, c, md);
    #1;
    check_model(name);
    @(negedge clk);
    key_pulse = 1'b0;
  endtask

  task automatic enter(logic [15:0] w, bit md, string name);
    for (int i = 0; i < D; i++) step(1'b1, w[15-4*i -: 4], md, name);
  endtask

  task automatic do_reset(string name);
    #2;
    rst = 1'b0;
    #1;
    check(name, 0, 0, 0, A, 0);
    model_reset();
    key_pulse = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit         k;
    logic [3:0] c;
    bit         md;
    int         st;
    bit         unl;
    bit         al;
    int         tr;
    int         dc;
  } vec_t;

  vec_t vt[$];
  int   al_cycles;

  initial begin
    rst = 1'b0; key_pulse = 1'b0; code = '0; mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", 0, 0, 0, A, 0);
    rst = 1'b1;

    // Table: correct entry, pulse during CHECK, relock, one wrong entry.
    vt.push_back('{1, 4'd1, 0, 0, 0, 0, 3, 1});
    vt.push_back('{1, 4'd2, 0, 0, 0, 0, 3, 2});
    vt.push_back('{1, 4'd3, 0, 0, 0, 0, 3, 3});
    vt.push_back('{1, 4'd4, 0, 1, 0, 0, 3, 4});
    vt.push_back('{1, 4'd7, 0, 2, 1, 0, 3, 0});
    vt.push_back('{0, 4'd0, 0, 2, 1, 0, 3, 0});
    vt.push_back('{1, 4'd0, 0, 0, 0, 0, 3, 0});
    vt.push_back('{1, 4'd1, 0, 0, 0, 0, 3, 1});
    vt.push_back('{1, 4'd2, 0, 0, 0, 0, 3, 2});
    vt.push_back('{1, 4'd3, 0, 0, 0, 0, 3, 3});
    vt.push_back('{1, 4'd5, 0, 1, 0, 0, 3, 4});
    vt.push_back('{0, 4'd0, 0, 0, 0, 0, 2, 0});
    foreach (vt[i]) begin
      step(vt[i].k, vt[i].c, vt[i].md, "vec_model");
      check($sformatf("vec%0d", i), vt[i].st, vt[i].unl, vt[i].al, vt[i].tr, vt[i].dc);
    end

    // Two more failures -> lockout; alarm must last exactly LC cycles.
    enter(16'h1235, 0, "fail2");
    step(0, 0, 0, "fail2_chk");
    check("tries_1", 0, 0, 0, 1, 0);
    enter(16'h1235, 0, "fail3");
    step(0, 0, 0, "fail3_chk");
    check("lockout_entry", 4, 0, 1, 0, 0);
    al_cycles = 1;
    for (int i = 0; i < 2 * LC; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 0, "lockout");
      if (alarm) al_cycles++;
      else break;
    end
    n_cmp++;
    if (al_cycles != LC) begin
      n_bad++;
      $display("FAIL alarm_len: got %0d cycles, want %0d", al_cycles, LC);
    end
    check("lockout_exit", 0, 0, 0, A, 0);
    enter(16'h1234, 0, "post_lock");
    step(0, 0, 0, "post_lock_chk");
    check("post_lock_open", 2, 1, 0, A, 0);

    // Change password to 9001, then old fails and new unlocks.
    step(1, 0, 1, "to_chg");
    check("in_chg", 3, 0, 0, A, 0);
    enter(16'h9001, 1, "chg");
    check("chg_done", 0, 0, 0, A, 0);
    enter(16'h1234, 0, "old_pwd");
    step(0, 0, 0, "old_chk");
    check("old_pwd_fails", 0, 0, 0, 2, 0);
    enter(16'h9001, 0, "new_pwd");
    step(0, 0, 0, "new_chk");
    check("new_pwd_opens", 2, 1, 0, A, 0);

    // Abort mid-change, with a simultaneous key pulse; password must stay 9001.
    step(1, 0, 1, "to_chg2");
    step(1, 4'd5, 1, "chg_d1");
    step(1, 4'd5, 1, "chg_d2");
    check("chg_two", 3, 0, 0, A, 2);
    step(1, 4'd5, 0, "abort");
    check("abort_open", 2, 1, 0, A, 0);
    step(1, 0, 0, "relock");
    enter(16'h9001, 0, "after_abort");
    step(0, 0, 0, "after_abort_chk");
    check("after_abort_open", 2, 1, 0, A, 0);

    // Reset mid-change, then default password works.
    step(1, 0, 1, "to_chg3");
    step(1, 4'd8, 1, "chg3_d1");
    do_reset("rst_mid_chg");
    enter(16'h1234, 0, "default_pwd");
    step(0, 0, 0, "default_chk");
    check("default_open", 2, 1, 0, A, 0);

    // Reset mid-lockout.
    step(1, 0, 0, "relock2");
    for (int n = 0; n < A; n++) begin
      enter(16'h0000, 0, "to_lock");
      step(0, 0, 0, "to_lock_chk");
    end
    repeat (5) step(1, 4'd3, 0, "lock_wait");
    check("mid_lock", 4, 0, 1, 0, 0);
    do_reset("rst_mid_lock");

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      bit         k;
      bit         md;
      logic [3:0] c;
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rand_rst");
        continue;
      end
      k  = ($urandom_range(0, 9) < 4);
      md = m_chg ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
      if (m_q.size() < D && $urandom_range(0, 3) != 0)
        c = m_pwd[(D - 1 - m_q.size()) * 4 +: 4];
      else
        c = 4'($urandom);
      step(k, c, md, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
